reg_bank_ctrl: RTL and testbench

- Parametrised register-bank controller; successor to the fixed-size register control block driven by the register-interface bench.
- Adds generic address/data width and depth, byte-strobed writes, and a configurable read latency.
- Adds a read-only upper region and an error response for illegal accesses.
- Sits behind the same sel/wr/ready request interface used by the test environment's driver and monitor.

---
 rtl/reg_bank_ctrl.sv | 92 +++++++++
 tb/tb_reg_bank_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_ctrl.sv
// rtl/reg_bank_ctrl.sv - parametrised register bank with byte-strobed writes,
// a read-only upper region, error pulses and a fixed read latency.
module reg_bank_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 200,
  parameter int RO_BASE = 192,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = 16'h1234,
  parameter int RD_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sel,
  input  logic                    wr,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ready,
  output logic                    err
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic accept, rd_done, addr_rw, rd_addr_ok;

  // Full-width unsigned compares so out-of-range indices never alias.
  assign addr_rw    = 32'(addr) < 32'(RO_BASE);
  assign rd_addr_ok = 32'(rd_addr) < 32'(DEPTH);
  assign accept     = sel && ready;
  assign rd_done    = (state == RD_WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (accept && !wr) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (cnt == 4'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= 4'd0;
      rd_addr <= '0;
      rdata   <= '0;
      err     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
    end else begin
      err <= 1'b0;
      if (accept && wr) begin
        if (addr_rw) begin
          for (int b = 0; b < NB; b++)
            if (wstrb[b]) mem[addr[IW-1:0]][8*b +: 8] <= wdata[8*b +: 8];
        end else begin
          err <= 1'b1;
        end
      end
      if (accept && !wr) begin
        rd_addr <= addr;
        cnt     <= 4'(RD_LATENCY - 1);
      end else if (state == RD_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Memory is sampled at completion, so writes committed before the read are visible.
      if (rd_done) begin
        rdata <= rd_addr_ok ? mem[rd_addr[IW-1:0]] : '0;
        err   <= !rd_addr_ok;
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// tb/tb_reg_bank_ctrl.sv - self-checking bench for reg_bank_ctrl: directed vectors,
// multi-cycle corner sequences and randomized accesses against a transaction model.
module tb_reg_bank_ctrl;

  localparam int DEPTH   = 200;
  localparam int RO_BASE = 192;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sel, wr;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [1:0]  wstrb;
  logic [15:0] rdata, rdata1, rdata8;
  logic        ready, ready1, ready8;
  logic        err, err1, err8;

  int tests = 0;
  int fails = 0;

  logic [15:0] mdl [0:DEPTH-1];
  logic [15:0] last_rd;

  always #5 clk = ~clk;

  reg_bank_ctrl #(.RD_LATENCY(2)) dut (
    .clk(clk), .rstn(rstn), .sel(sel), .wr(wr), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready), .err(err));

  reg_bank_ctrl #(.RD_LATENCY(1)) dut1 (
    .clk(clk), .rstn(rstn), .sel(sel), .wr(wr), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata1), .ready(ready1), .err(err1));

  reg_bank_ctrl #(.RD_LATENCY(8)) dut8 (
    .clk(clk), .rstn(rstn), .sel(sel), .wr(wr), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata8), .ready(ready8), .err(err8));

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  wstrb;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mdl_write(input logic [7:0] a, input logic [15:0] d, input logic [1:0] s);
    if (int'(a) < RO_BASE) begin
      if (s[0]) mdl[a][7:0]  = d[7:0];
      if (s[1]) mdl[a][15:8] = d[15:8];
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 16'h1234;
    last_rd = 16'h0000;
  endtask

  task automatic access(input logic w, input logic [7:0] a, input logic [15:0] d,
                        input logic [1:0] s, input logic [15:0] exp_rd,
                        input logic exp_e, input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    sel = 1'b1; wr = w; addr = a; wdata = d; wstrb = s;
    @(negedge clk);
    sel = 1'b0; wr = 1'b0;
    lat = 0;
    while (!ready && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdata"}, rdata, exp_rd);
    chk({tag, "_err"}, err, exp_e);
    @(negedge clk);
    chk({tag, "_err_clr"}, err, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int low1, low2, low8;
    logic any_err;
    logic        w;
    logic [7:0]  a;
    logic [15:0] d, e_rd;
    logic [1:0]  s;

    vecs[0]  = '{1'b0, 8'h05, 16'h0000, 2'b00, 16'h1234, 1'b0};
    vecs[1]  = '{1'b1, 8'h10, 16'hABCD, 2'b01, 16'h1234, 1'b0};
    vecs[2]  = '{1'b0, 8'h10, 16'h0000, 2'b00, 16'h12CD, 1'b0};
    vecs[3]  = '{1'b1, 8'h10, 16'h5500, 2'b10, 16'h12CD, 1'b0};
    vecs[4]  = '{1'b0, 8'h10, 16'h0000, 2'b00, 16'h55CD, 1'b0};
    vecs[5]  = '{1'b1, 8'hC0, 16'hFFFF, 2'b11, 16'h55CD, 1'b1};
    vecs[6]  = '{1'b0, 8'hC0, 16'h0000, 2'b00, 16'h1234, 1'b0};
    vecs[7]  = '{1'b0, 8'hC8, 16'h0000, 2'b00, 16'h0000, 1'b1};
    vecs[8]  = '{1'b1, 8'hFF, 16'hFFFF, 2'b11, 16'h0000, 1'b1};
    vecs[9]  = '{1'b0, 8'hC7, 16'h0000, 2'b00, 16'h1234, 1'b0};
    vecs[10] = '{1'b1, 8'h00, 16'hBEEF, 2'b00, 16'h1234, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 16'h0000, 2'b00, 16'h1234, 1'b0};

    rstn = 1'b0; sel = 1'b0; wr = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    mdl_reset();
    repeat (3) @(negedge clk);
    chk("reset_ready", ready, 1'b1);
    chk("reset_rdata", rdata, 16'h0000);
    chk("reset_err", err, 1'b0);
    rstn = 1'b1;

    // Same read issued to all three latency variants; count low-ready cycles of each.
    @(negedge clk);
    sel = 1'b1; wr = 1'b0; addr = 8'h05;
    @(negedge clk);
    sel = 1'b0;
    low1 = 0; low2 = 0; low8 = 0; any_err = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (!ready1) low1++;
      if (!ready)  low2++;
      if (!ready8) low8++;
      any_err = any_err | err | err1 | err8;
      @(negedge clk);
    end
    chk("lat1_low", low1, 1);
    chk("lat2_low", low2, 2);
    chk("lat8_low", low8, 8);
    chk("lat1_rdata", rdata1, 16'h1234);
    chk("lat2_rdata", rdata, 16'h1234);
    chk("lat8_rdata", rdata8, 16'h1234);
    chk("lat_err", any_err, 1'b0);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) mdl_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
      access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
             vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].wr ? 0 : 2,
             $sformatf("vec%0d", i));
    end
    last_rd = 16'h1234;

    // Write presented during RD_WAIT must be ignored.
    @(negedge clk);
    sel = 1'b1; wr = 1'b0; addr = 8'h30;
    @(negedge clk);
    chk("ign_ready0", ready, 1'b0);
    wr = 1'b1; addr = 8'h20; wdata = 16'hDEAD; wstrb = 2'b11;
    @(negedge clk);
    chk("ign_ready1", ready, 1'b0);
    sel = 1'b0; wr = 1'b0;
    @(negedge clk);
    chk("ign_ready_back", ready, 1'b1);
    chk("ign_rd30", rdata, mdl[8'h30]);
    access(1'b0, 8'h20, 16'h0, 2'b00, 16'h1234, 1'b0, 2, "ign_rd20");

    // Back-to-back writes, then a read of the first address in the very next cycle.
    @(negedge clk);
    sel = 1'b1; wr = 1'b1; addr = 8'h40; wdata = 16'hA5A5; wstrb = 2'b11;
    @(negedge clk);
    chk("b2b_ready0", ready, 1'b1);
    chk("b2b_err0", err, 1'b0);
    addr = 8'h41; wdata = 16'h5A5A;
    @(negedge clk);
    chk("b2b_ready1", ready, 1'b1);
    wr = 1'b0; addr = 8'h40;
    @(negedge clk);
    sel = 1'b0;
    chk("raw_ready0", ready, 1'b0);
    @(negedge clk);
    chk("raw_ready1", ready, 1'b0);
    @(negedge clk);
    chk("raw_ready2", ready, 1'b1);
    chk("raw_rdata", rdata, 16'hA5A5);
    mdl[8'h40] = 16'hA5A5;
    mdl[8'h41] = 16'h5A5A;

    // Held sel: the next read is accepted in the cycle ready returns.
    @(negedge clk);
    sel = 1'b1; wr = 1'b0; addr = 8'h41;
    @(negedge clk);
    chk("pipe_low0", ready, 1'b0);
    @(negedge clk);
    chk("pipe_low1", ready, 1'b0);
    @(negedge clk);
    chk("pipe_back", ready, 1'b1);
    chk("pipe_rdata0", rdata, 16'h5A5A);
    addr = 8'h40;
    @(negedge clk);
    chk("pipe_reaccept", ready, 1'b0);
    sel = 1'b0;
    @(negedge clk);
    chk("pipe_low2", ready, 1'b0);
    @(negedge clk);
    chk("pipe_back2", ready, 1'b1);
    chk("pipe_rdata1", rdata, 16'hA5A5);

    // Reset in the middle of a read.
    @(negedge clk);
    sel = 1'b1; wr = 1'b0; addr = 8'h10;
    @(negedge clk);
    sel = 1'b0;
    chk("rst_mid_busy", ready, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_ready", ready, 1'b1);
    chk("rst_mid_rdata", rdata, 16'h0000);
    chk("rst_mid_err", err, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    mdl_reset();
    access(1'b0, 8'h10, 16'h0, 2'b00, 16'h1234, 1'b0, 2, "rst_rd10");
    last_rd = 16'h1234;

    for (int i = 0; i < 300; i++) begin
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       a = 8'($urandom_range(0, 255));
        1:       a = 8'($urandom_range(8'h10, 8'h17));
        default: a = 8'($urandom_range(8'hBE, 8'hC9));
      endcase
      d = 16'($urandom);
      s = 2'($urandom_range(0, 3));
      if (w) begin
        mdl_write(a, d, s);
        access(1'b1, a, d, s, last_rd, int'(a) >= RO_BASE, 0, "rnd_wr");
      end else begin
        e_rd = (int'(a) < DEPTH) ? mdl[a] : 16'h0000;
        access(1'b0, a, 16'h0, 2'b00, e_rd, int'(a) >= DEPTH, 2, "rnd_rd");
        last_rd = e_rd;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
